// File: rtl/pin_uart_tx_pkg.sv
// Shared constants for the pin-driven UART transmitter: CPU pin word layout
// and the transmit FSM state encoding.
package pin_uart_tx_pkg;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned CHAR_W          = 8;

  localparam int unsigned PIN_TX_VALID    = 0;
  localparam int unsigned PIN_HALT        = 1;
  localparam int unsigned PIN_TX_DATA_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with wrap-bit pointers; push and pop may coincide
// even when full, in which case both are accepted.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i & ~empty_c;
  assign wr_en   = push_i & (~full_c | rd_en);
  assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pin_uart_tx.sv
// Pin-driven 8N1 UART transmitter: edge-detects the CPU char strobe, queues
// characters, serialises them back to back, and latches halt/overflow.
module pin_uart_tx
  import pin_uart_tx_pkg::*;
#(
  parameter int unsigned BITNESS      = WORD_W,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITNESS-1:0] pin_out,
  output logic               ready,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic               halted,
  output logic               drained
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("pin_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (BITNESS < PIN_TX_DATA_LSB + CHAR_W) begin : g_bad_bitness
    $error("pin_uart_tx: BITNESS too narrow for the pin layout");
  end

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              tx_q;
  logic              tx_d;
  logic              busy_q;
  logic              busy_d;
  logic              strobe_q;
  logic              halted_q;
  logic              overflow_q;

  logic              strobe_edge;
  logic              halt_pin;
  logic              push;
  logic              pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        pin_char;

  assign pin_char    = pin_out[PIN_TX_DATA_LSB +: CHAR_W];
  assign halt_pin    = pin_out[PIN_HALT];
  assign strobe_edge = pin_out[PIN_TX_VALID] & ~strobe_q;
  // A halt on the same cycle as the edge already blocks the push.
  assign push        = strobe_edge & ~halted_q & ~halt_pin;

  if (BITNESS > PIN_TX_DATA_LSB + CHAR_W) begin : g_unused_pins
    logic unused_hi;
    assign unused_hi = ^pin_out[BITNESS-1:PIN_TX_DATA_LSB+CHAR_W];
  end

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (pin_char),
    .pop_i   (pop),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Next-state logic; tx/busy are computed one cycle ahead so they leave registers.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      strobe_q   <= pin_out[PIN_TX_VALID];
      halted_q   <= halted_q | halt_pin;
      overflow_q <= overflow_q | (push & fifo_full & ~pop);
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign halted   = halted_q;
  assign ready    = ~fifo_full & ~halted_q;
  assign drained  = halted_q & fifo_empty & ~busy_q;

endmodule

// File: tb/tb_pin_uart_tx.sv
// Bench for pin_uart_tx: queue-and-frame reference model checked every cycle,
// a UART receiver on tx, directed scenarios and randomized pin traffic.
module tb_pin_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int BW    = 16;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] pin_out;
  logic          ready;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic          halted;
  logic          drained;

  always #5 clk = ~clk;

  pin_uart_tx #(
    .BITNESS      (BW),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_out  (pin_out),
    .ready    (ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .halted   (halted),
    .drained  (drained)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: pending characters and the frame currently on the line.
  logic [7:0] m_q[$];
  logic       m_act;
  int         m_pos;
  logic [7:0] m_char;
  logic       m_halt;
  logic       m_ovf;
  logic       m_prev;

  function automatic void model_reset();
    m_q.delete();
    m_act  = 1'b0;
    m_pos  = 0;
    m_char = 8'h00;
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endfunction

  function automatic void model_step(input logic s, input logic h, input logic [7:0] d);
    int sz = m_q.size();
    bit pu = s && !m_prev && !m_halt && !h;
    bit po = (sz != 0) && (!m_act || m_pos == FRAME - 1);
    if (po) begin
      m_char = m_q.pop_front();
      m_act  = 1'b1;
      m_pos  = 0;
    end else if (m_act) begin
      if (m_pos == FRAME - 1) m_act = 1'b0;
      else m_pos++;
    end
    if (pu) begin
      if (sz < DEPTH || po) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (h) m_halt = 1'b1;
    m_prev = s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step(pin_out[0], pin_out[1], pin_out[9:2]);
  end

  function automatic logic frame_bit(input logic [7:0] c, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return c[slot-1];
  endfunction

  function automatic logic [5:0] exp_vec();
    logic e_tx = m_act ? frame_bit(m_char, m_pos / CPB) : 1'b1;
    return {e_tx, (m_q.size() < DEPTH) && !m_halt, m_act, m_ovf, m_halt,
            m_halt && (m_q.size() == 0) && !m_act};
  endfunction

  // UART receiver on tx, mid-bit sampling; rx_cnt holds the frame position.
  logic [7:0] rx_log[$];
  logic       rx_act;
  int         rx_cnt;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
        rx_byte[3'(rx_cnt / CPB - 1)] <= tx;
      if (rx_cnt == FRAME - 2) rx_log.push_back(rx_byte);
      if (rx_cnt == FRAME - 1) rx_act <= 1'b0;
    end
  end

  // Length of the most recent contiguous busy run.
  int run_len  = 0;
  int last_run = 0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      run_len <= 0;
    end else if (busy) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rst === 1'b1)
      chk("cycle_outputs", 32'({tx, ready, busy, overflow, halted, drained}), 32'(exp_vec()));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    pin_out = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_edge(input logic [7:0] c);
    pin_out[9:2] = c;
    pin_out[0]   = 1'b1;
    tick();
    pin_out[0]   = 1'b0;
    tick();
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int quiet = 0;
    int n     = 0;
    while (quiet < 3 && n < limit) begin
      tick();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk(name, 32'(n < limit), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    logic       prev_b;
    logic [9:0] f41;

    rst     = 1'b1;
    pin_out = '0;
    #1 rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",       32'(tx),       32'd1);
    chk("rst_ready",    32'(ready),    32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_drained",  32'(drained),  32'd0);
    rst = 1'b1;
    tick();

    // Single 0x41 frame: start bit two cycles after the edge, bits LSB first.
    base         = rx_log.size();
    f41          = 10'b1010000010;
    pin_out[9:2] = 8'h41;
    pin_out[0]   = 1'b1;
    tick();
    pin_out[0]   = 1'b0;
    tick();
    for (int k = 0; k < FRAME; k++) begin
      chk("t1_tx_bit", 32'(tx), 32'(f41[k / CPB]));
      tick();
    end
    chk("t1_busy_after", 32'(busy), 32'd0);
    wait_quiet("t1_drain", 200);
    chk("t1_busy_len", 32'(last_run), 32'd40);
    chk("t1_rx_count", 32'(rx_log.size()), 32'(base + 1));
    chk("t1_rx_char",  32'(rx_log[base]), 32'h41);

    // Strobe held high for 20 cycles yields a single frame.
    base         = rx_log.size();
    pin_out[9:2] = 8'h55;
    pin_out[0]   = 1'b1;
    repeat (20) tick();
    pin_out[0]   = 1'b0;
    wait_quiet("t2_drain", 300);
    chk("t2_rx_count", 32'(rx_log.size()), 32'(base + 1));
    chk("t2_rx_char",  32'(rx_log[base]), 32'h55);
    chk("t2_ready",    32'(ready), 32'd1);

    // Ten edges on alternate cycles: 0 in flight, 1..8 queued, 9 dropped.
    base = rx_log.size();
    for (int i = 0; i < 10; i++) begin
      push_edge(8'(i));
      if (i == 7) chk("t3_ready_before_full", 32'(ready), 32'd1);
      if (i == 8) chk("t3_ready_full", 32'(ready), 32'd0);
      if (i == 8) chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
    end
    chk("t3_overflow", 32'(overflow), 32'd1);
    wait_quiet("t3_drain", 1000);
    chk("t3_rx_count", 32'(rx_log.size()), 32'(base + 9));
    for (int j = 0; j < 9; j++) chk("t3_rx_seq", 32'(rx_log[base + j]), 32'(j));
    do_reset();
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);

    // Back-to-back characters: one unbroken 80-cycle busy run.
    base = rx_log.size();
    push_edge(8'h31);
    push_edge(8'h32);
    wait_quiet("t4_drain", 400);
    chk("t4_busy_len", 32'(last_run), 32'd80);
    chk("t4_rx_count", 32'(rx_log.size()), 32'(base + 2));
    chk("t4_rx_first", 32'(rx_log[base]), 32'h31);
    chk("t4_rx_second", 32'(rx_log[base + 1]), 32'h32);

    // Halt: later pushes ignored, drained rises once the frame finishes.
    base = rx_log.size();
    push_edge(8'h48);
    pin_out[1] = 1'b1;
    tick();
    pin_out[1] = 1'b0;
    chk("t5_halted", 32'(halted),  32'd1);
    chk("t5_ready",  32'(ready),   32'd0);
    chk("t5_not_drained", 32'(drained), 32'd0);
    push_edge(8'h49);
    n      = 0;
    prev_b = busy;
    while (!drained && n < 300) begin
      prev_b = busy;
      tick();
      n++;
    end
    chk("t5_drain_timeout", 32'(n < 300), 32'd1);
    chk("t5_busy_before_drained", 32'(prev_b), 32'd1);
    chk("t5_busy_at_drained", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("t5_drained_holds", 32'(drained), 32'd1);
    chk("t5_rx_count", 32'(rx_log.size()), 32'(base + 1));
    chk("t5_rx_char",  32'(rx_log[base]), 32'h48);
    do_reset();

    // Reset during data bit 3 of 0xA5 (bit 3 is 0).
    base = rx_log.size();
    push_edge(8'hA5);
    repeat (8) tick();
    pin_out[1] = 1'b1;
    tick();
    pin_out[1] = 1'b0;
    repeat (8) tick();
    chk("t6_bit3_low", 32'(tx), 32'd0);
    chk("t6_halted_before", 32'(halted), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_tx",       32'(tx),       32'd1);
    chk("t6_busy",     32'(busy),     32'd0);
    chk("t6_ready",    32'(ready),    32'd1);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_halted",   32'(halted),   32'd0);
    chk("t6_drained",  32'(drained),  32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    repeat (3) tick();
    chk("t6_no_partial", 32'(rx_log.size()), 32'(base));
    push_edge(8'h3C);
    wait_quiet("t6_drain", 200);
    chk("t6_rx_count", 32'(rx_log.size()), 32'(base + 1));
    chk("t6_rx_char",  32'(rx_log[base]), 32'h3C);

    // Randomized pin traffic at several strobe densities.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      repeat (500) begin
        if ($urandom_range(0, 1 + seg * 6) == 0) pin_out[0] = ~pin_out[0];
        pin_out[9:2]  = 8'($urandom);
        pin_out[15:10] = 6'($urandom);
        pin_out[1]    = ($urandom_range(0, 399) == 0);
        tick();
      end
      pin_out = '0;
      wait_quiet("rand_drain", 600);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
